// File: rtl/ntt_fwd_engine_if.sv
// Coefficient load/read and start/done handshake for ntt_fwd_engine.
// master: the controlling block (or bench); slave: the engine.
interface ntt_fwd_engine_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int WIDTH      = 32
);
    logic                  start;
    logic                  done;
    logic                  busy;
    logic                  load_coeff;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [WIDTH-1:0]      load_data;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [WIDTH-1:0]      read_data;

    modport master (
        output start, load_coeff, load_addr, load_data, read_addr,
        input  done, busy, read_data
    );

    modport slave (
        input  start, load_coeff, load_addr, load_data, read_addr,
        output done, busy, read_data
    );
endinterface

// File: rtl/ntt_fwd_engine.sv
// In-place forward negacyclic NTT over Z_Q (Cooley-Tukey DIT, natural-order
// input, bit-reversed output). PARALLEL butterflies of one stage complete per
// cycle, fully combinational read/multiply/writeback.
// Optional macro NTT_FWD_ASSERT_EN compiles in simulation-only parameter and
// protocol checks; functional behaviour is unchanged by it.

// One butterfly: x' = x + z*y, y' = x - z*y, all mod Q with inputs in [0,Q).
module ntt_bfly_lane #(
    parameter int WIDTH          = 32,
    parameter int Q              = 8380417,
    parameter int REDUCTION_TYPE = 0
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] x_o,
    output logic [WIDTH-1:0] y_o
);
    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] t;
    logic [WIDTH:0]   sum;

    assign prod = PW'(y) * PW'(z);

    if (REDUCTION_TYPE == 1) begin : g_barrett
        // mu = floor(4^KB / Q); estimate is at most two Q short of the true quotient
        localparam int           KB = $clog2(Q);
        localparam int           XW = 3 * WIDTH + 2;
        localparam logic [XW-1:0] QX = XW'(Q);
        localparam logic [XW-1:0] MU = (XW'(1) << (2 * KB)) / QX;

        logic [XW-1:0] qe, r0, r1, r2;

        // Barrett reduction with two conditional corrections
        always_comb begin
            qe = (XW'(prod) * MU) >> (2 * KB);
            r0 = XW'(prod) - qe * QX;
            r1 = (r0 >= QX) ? r0 - QX : r0;
            r2 = (r1 >= QX) ? r1 - QX : r1;
            t  = WIDTH'(r2);
        end
    end else begin : g_rem
        assign t = WIDTH'(prod % PW'(Q));
    end

    // Modular add/sub; the sub wraps through WIDTH bits which is exact mod 2^WIDTH
    always_comb begin
        sum = {1'b0, x} + {1'b0, t};
        x_o = (sum >= (WIDTH+1)'(Q)) ? WIDTH'(sum - (WIDTH+1)'(Q)) : WIDTH'(sum);
        y_o = (x >= t) ? x - t : x + WIDTH'(Q) - t;
    end
endmodule

module ntt_fwd_engine #(
    parameter int N              = 256,
    parameter int WIDTH          = 32,
    parameter int Q              = 8380417,
    parameter int ADDR_WIDTH     = 8,
    parameter int ROOT           = 1753,
    parameter int REDUCTION_TYPE = 0,
    parameter int PARALLEL       = 1
) (
    input logic            clk,
    input logic            rst_n,
    ntt_fwd_engine_if.slave bus
);
    localparam int LOGN = ADDR_WIDTH;
    localparam int HALF = N / 2;
    localparam int SW   = $clog2(LOGN);
    localparam int BW   = ADDR_WIDTH - 1;
    localparam logic [BW-1:0] LAST_B = BW'(HALF - PARALLEL);
    localparam logic [SW-1:0] LAST_S = SW'(LOGN - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t          state, state_n;
    logic [SW-1:0]   stage;
    logic [BW-1:0]   bidx;
    logic            last;

    logic [WIDTH-1:0] mem      [N];
    logic [WIDTH-1:0] zeta_rom [N];

    logic [PARALLEL-1:0][ADDR_WIDTH-1:0] lo_addr, hi_addr;
    logic [PARALLEL-1:0][WIDTH-1:0]      lo_new, hi_new;

    // ROOT^brv(k) mod Q by square-and-multiply; evaluated only at elaboration
    function automatic logic [63:0] zeta_val(input int k);
        logic [63:0] acc, base;
        int          e;
        e = 0;
        for (int i = 0; i < LOGN; i++)
            if (k[i]) e = e | (1 << (LOGN - 1 - i));
        acc  = 64'd1;
        base = 64'(ROOT) % 64'(Q);
        for (int i = 0; i < LOGN; i++) begin
            if (e[i]) acc = (acc * base) % 64'(Q);
            base = (base * base) % 64'(Q);
        end
        return acc;
    endfunction

    for (genvar i = 0; i < N; i++) begin : g_zeta
        localparam logic [WIDTH-1:0] ZV = WIDTH'(zeta_val(i));
        assign zeta_rom[i] = ZV;
    end

    // Butterfly b of stage s: block b/len, offset b%len, twiddle index 2^s + block
    for (genvar p = 0; p < PARALLEL; p++) begin : g_lane
        logic [ADDR_WIDTH-1:0] b, len, blk, off, j_lo, j_hi, k;

        // Address and twiddle selection for this lane
        always_comb begin
            b    = {1'b0, bidx} + ADDR_WIDTH'(p);
            len  = ADDR_WIDTH'(HALF) >> stage;
            blk  = b >> (LOGN - 1 - int'(stage));
            off  = b & (len - 1'b1);
            j_lo = (blk << (LOGN - int'(stage))) | off;
            j_hi = j_lo | len;
            k    = (ADDR_WIDTH'(1) << stage) | blk;
        end

        ntt_bfly_lane #(
            .WIDTH          (WIDTH),
            .Q              (Q),
            .REDUCTION_TYPE (REDUCTION_TYPE)
        ) u_lane (
            .x   (mem[j_lo]),
            .y   (mem[j_hi]),
            .z   (zeta_rom[k]),
            .x_o (lo_new[p]),
            .y_o (hi_new[p])
        );

        assign lo_addr[p] = j_lo;
        assign hi_addr[p] = j_hi;
    end

    assign last     = (state == S_RUN) && (bidx == LAST_B) && (stage == LAST_S);
    assign bus.done = (state == S_FINISH);
    assign bus.busy = (state == S_RUN);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state: start only honoured in IDLE, FINISH lasts one cycle
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (bus.start) state_n = S_RUN;
            S_RUN:    if (last)      state_n = S_FINISH;
            S_FINISH:                state_n = S_IDLE;
            default:                 state_n = S_IDLE;
        endcase
    end

    // Butterfly group / stage counters, parked at zero outside RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bidx  <= '0;
            stage <= '0;
        end else if (state != S_RUN || last) begin
            bidx  <= '0;
            stage <= '0;
        end else if (bidx == LAST_B) begin
            bidx  <= '0;
            stage <= stage + 1'b1;
        end else begin
            bidx  <= bidx + BW'(PARALLEL);
        end
    end

    // Coefficient store: butterfly writeback in RUN, host loads otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (state == S_RUN) begin
            for (int p = 0; p < PARALLEL; p++) begin
                mem[lo_addr[p]] <= lo_new[p];
                mem[hi_addr[p]] <= hi_new[p];
            end
        end else if (bus.load_coeff) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    // Registered read port, active in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.read_data <= '0;
        else        bus.read_data <= mem[bus.read_addr];
    end

`ifdef NTT_FWD_ASSERT_EN
    if ((N & (N - 1)) != 0) begin : g_bad_n
        $error("ntt_fwd_engine: N=%0d is not a power of two", N);
    end
    if (ADDR_WIDTH != $clog2(N)) begin : g_bad_aw
        $error("ntt_fwd_engine: ADDR_WIDTH=%0d does not match log2(N)", ADDR_WIDTH);
    end
    if ((Q % (2 * N)) != 1) begin : g_bad_q
        $error("ntt_fwd_engine: Q=%0d is not 1 mod 2N", Q);
    end

    // Out-of-range load data and requests that the busy engine will drop
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.load_coeff && bus.load_data >= WIDTH'(Q))
                $error("ntt_fwd_engine: load_data %0d not below Q", bus.load_data);
            if (bus.busy && (bus.load_coeff || bus.start))
                $warning("ntt_fwd_engine: load/start while busy is ignored");
        end
    end
`endif
endmodule

// File: tb/tb_ntt_fwd_engine.sv
// Directed bench for ntt_fwd_engine: default instance (direct remainder,
// PARALLEL=1) and a Barrett/PARALLEL=4 instance sharing load and read buses.
module tb_ntt_fwd_engine;
    localparam int N  = 256;
    localparam int Q  = 8380417;
    localparam int B1 = 1024;
    localparam int B4 = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0, load_coeff = 1'b0;
    logic [7:0] load_addr = '0, read_addr = '0;
    logic [31:0] load_data = '0;

    int n_chk = 0;
    int n_fail = 0;

    logic [63:0] vin  [N];
    logic [63:0] expv [N];

    always #5 clk = ~clk;

    ntt_fwd_engine_if #(.ADDR_WIDTH(8), .WIDTH(32)) bus_a ();
    ntt_fwd_engine_if #(.ADDR_WIDTH(8), .WIDTH(32)) bus_b ();

    assign bus_a.start      = start_a;
    assign bus_a.load_coeff = load_coeff;
    assign bus_a.load_addr  = load_addr;
    assign bus_a.load_data  = load_data;
    assign bus_a.read_addr  = read_addr;
    assign bus_b.start      = start_b;
    assign bus_b.load_coeff = load_coeff;
    assign bus_b.load_addr  = load_addr;
    assign bus_b.load_data  = load_data;
    assign bus_b.read_addr  = read_addr;

    ntt_fwd_engine dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

    ntt_fwd_engine #(.REDUCTION_TYPE(1), .PARALLEL(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Plain reference NTT written straight from the algorithm description
    function automatic logic [63:0] ref_zeta(input int k);
        logic [63:0] acc;
        int e;
        e = 0;
        for (int i = 0; i < 8; i++) if (k[i]) e = e | (1 << (7 - i));
        acc = 64'd1;
        for (int i = 0; i < e; i++) acc = (acc * 64'd1753) % 64'(Q);
        return acc;
    endfunction

    task automatic ref_ntt();
        int k;
        logic [63:0] z, t;
        for (int i = 0; i < N; i++) expv[i] = vin[i];
        k = 1;
        for (int len = N / 2; len > 0; len = len / 2) begin
            for (int s = 0; s < N; s += 2 * len) begin
                z = ref_zeta(k);
                k++;
                for (int j = s; j < s + len; j++) begin
                    t = (z * expv[j + len]) % 64'(Q);
                    expv[j + len] = (expv[j] + 64'(Q) - t) % 64'(Q);
                    expv[j]       = (expv[j] + t) % 64'(Q);
                end
            end
        end
    endtask

    task automatic set_impulse(input logic [63:0] v);
        for (int i = 0; i < N; i++) vin[i] = 64'd0;
        vin[0] = v;
    endtask

    task automatic fill_exp(input logic [63:0] v);
        for (int i = 0; i < N; i++) expv[i] = v;
    endtask

    // One load per cycle; optionally raise start together with the final load
    task automatic load_all(input bit with_start);
        for (int i = 0; i < N; i++) begin
            load_coeff = 1'b1;
            load_addr  = 8'(i);
            load_data  = vin[i][31:0];
            if (with_start && i == N - 1) begin
                start_a = 1'b1;
                start_b = 1'b1;
            end
            @(negedge clk);
        end
        load_coeff = 1'b0;
        start_a    = 1'b0;
        start_b    = 1'b0;
    endtask

    task automatic pulse_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc, input string tag);
        int cnt = 0;
        int guard = 0;
        while (!bus_a.done && guard < 4000) begin
            if (bus_a.busy) cnt++;
            guard++;
            @(negedge clk);
        end
        chk($sformatf("%s_busy_cycles", tag), 64'(cnt), 64'(exp_cyc));
        chk($sformatf("%s_done", tag), 64'(bus_a.done), 64'd1);
        chk($sformatf("%s_busy_at_done", tag), 64'(bus_a.busy), 64'd0);
        @(negedge clk);
        chk($sformatf("%s_done_drop", tag), 64'(bus_a.done), 64'd0);
    endtask

    // Streamed reads: a new address every cycle checks the one-cycle latency
    task automatic read_all(input bit both, input string tag);
        read_addr = 8'd0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_a[%0d]", tag, i), 64'(bus_a.read_data), expv[i]);
            if (both) chk($sformatf("%s_b[%0d]", tag, i), 64'(bus_b.read_data), expv[i]);
            if (i < N - 1) read_addr = 8'(i + 1);
            @(negedge clk);
        end
    endtask

    initial begin
        int cnt_a, cnt_b, guard;
        bit da, db, saw_done;

        // reset state
        #12;
        chk("rst_done", 64'(bus_a.done), 64'd0);
        chk("rst_busy", 64'(bus_a.busy), 64'd0);
        chk("rst_rdata", 64'(bus_a.read_data), 64'd0);
        chk("rst_b_busy", 64'(bus_b.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset mid-transform aborts and clears memory
        for (int i = 0; i < N; i++) vin[i] = 64'(i + 1);
        load_all(1'b0);
        read_addr = 8'd5;
        pulse_a();
        repeat (100) @(negedge clk);
        chk("mid_busy", 64'(bus_a.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_done", 64'(bus_a.done), 64'd0);
        chk("mid_rst_busy", 64'(bus_a.busy), 64'd0);
        chk("mid_rst_rdata", 64'(bus_a.read_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (20) begin
            if (bus_a.done || bus_a.busy) saw_done = 1'b1;
            @(negedge clk);
        end
        chk("mid_rst_no_done", 64'(saw_done), 64'd0);
        fill_exp(64'd0);
        read_all(1'b1, "rst_mem");

        // impulse: every output equals a[0]
        set_impulse(64'd1);
        load_all(1'b0);
        pulse_a();
        wait_done(B1, "imp");
        fill_exp(64'd1);
        read_all(1'b0, "imp");

        // Q-1 scaling, then a back-to-back start the cycle after done
        set_impulse(64'(Q - 1));
        load_all(1'b0);
        pulse_a();
        wait_done(B1, "qm1");
        fill_exp(64'(Q - 1));
        read_all(1'b0, "qm1");
        set_impulse(64'd5);
        load_all(1'b0);
        pulse_a();
        wait_done(B1, "five");
        for (int i = 0; i < N; i++) vin[i] = 64'd5;
        pulse_a();
        wait_done(B1, "b2b");
        ref_ntt();
        read_all(1'b0, "b2b");
        set_impulse(64'd5);
        load_all(1'b0);
        pulse_a();
        wait_done(B1, "five2");
        fill_exp(64'd5);
        read_all(1'b0, "five2");

        // known answer a[i]=i on both instances, start in the same cycle as the last load
        for (int i = 0; i < N; i++) vin[i] = 64'(i);
        load_all(1'b1);
        cnt_a = 0; cnt_b = 0; guard = 0; da = 1'b0; db = 1'b0;
        while (!(da && db) && guard < 3000) begin
            if (bus_a.busy) cnt_a++;
            if (bus_b.busy) cnt_b++;
            if (bus_a.done) da = 1'b1;
            if (bus_b.done) db = 1'b1;
            guard++;
            @(negedge clk);
        end
        chk("kat_a_cycles", 64'(cnt_a), 64'(B1));
        chk("kat_b_cycles", 64'(cnt_b), 64'(B4));
        chk("kat_a_done", 64'(da), 64'd1);
        chk("kat_b_done", 64'(db), 64'd1);
        ref_ntt();
        read_all(1'b1, "kat");

        // start and loads while running are ignored
        load_all(1'b0);
        pulse_a();
        for (int i = 0; i < 20; i++) begin
            start_a    = (i % 3 == 0);
            load_coeff = (i % 2 == 0);
            load_addr  = 8'(i);
            load_data  = 32'd999;
            @(negedge clk);
        end
        start_a    = 1'b0;
        load_coeff = 1'b0;
        wait_done(B1 - 20, "prot");
        read_all(1'b0, "prot");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    // Hard stop in case a wait above never returns
    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ntt_fwd_engine.md
Name: ntt_fwd_engine

Overview:
- In-place forward negacyclic NTT engine over Z_Q for one N-coefficient polynomial.
- Flow: load coefficients, pulse start, wait for a one-cycle done pulse, read back the transform.
- Used by the polynomial-multiplier top level to transform operands A and B sequentially.
- The same instance is reused without reset between transforms.

Parameters:
- N, 256: polynomial length; power of two, ≥4.
- WIDTH, 32: coefficient storage/port width; must be ≥ clog2(Q).
- Q, 8380417: prime modulus, Q ≡ 1 mod 2N.
- ADDR_WIDTH, 8: coefficient address width, = log2(N).
- ROOT, 1753: primitive 2N-th root of unity psi mod Q.
- REDUCTION_TYPE, 0: modular multiply reduction. 0 = direct remainder, 1 = Barrett. Results are bit-identical for both.
- PARALLEL, 1: butterflies per cycle; power of two dividing N/2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin transform; sampled only when idle.
- done  out  1  one-cycle pulse when the transform completes.
- busy  out  1  high while the transform is running.
- load_coeff  in  1  coefficient write strobe.
- load_addr  in  ADDR_WIDTH  write index.
- load_data  in  WIDTH  write value, must be in [0,Q).
- read_addr  in  ADDR_WIDTH  read index.
- read_data  out  WIDTH  registered coefficient at read_addr.

Behaviour:
- Reset is asynchronous on rst_n, active-low; clock is clk. All state is on rising clk.
- Reset values: done=0, busy=0, read_data=0, all N coefficients=0, FSM=IDLE.
- Reset asserted mid-transform aborts immediately; no done pulse is produced.
- FSM states: IDLE, RUN, FINISH.
- IDLE -> RUN on start=1.
- RUN -> FINISH after the last butterfly group is written back.
- FINISH -> IDLE unconditionally after one cycle. done=1 only in FINISH.
- busy=1 in RUN only.
- Load: when not busy and load_coeff=1, mem[load_addr] <= load_data at the clock edge.
  - Loads while busy are ignored.
  - Load and start in the same cycle: the load is written first; the transform uses the new value.
- start while busy or in FINISH is ignored.
- Read: read_data <= mem[read_addr] every cycle, with 1-cycle latency, in any state. Data read during RUN is unspecified.
- Algorithm: Cooley-Tukey decimation-in-time. Input in natural order, output in bit-reversed order (Dilithium convention).
  - len = N/2 down to 1; k starts at 1.
  - For each block start s (step 2*len): z = zeta[k++].
  - For j in [s, s+len): t = z*a[j+len] mod Q; a[j+len] = (a[j]-t) mod Q; a[j] = (a[j]+t) mod Q.
  - zeta[k] = ROOT^brv_log2N(k) mod Q, held in a twiddle ROM computed at elaboration by a constant function. No runtime twiddle generation.
- Arithmetic:
  - Full 2*WIDTH-bit product, reduced to [0,Q).
  - Add: subtract Q if the sum is ≥ Q.
  - Sub: add Q if the difference is negative.
  - All stored values always lie in [0,Q).
- Schedule:
  - PARALLEL independent butterflies of the same stage per cycle.
  - Combinational read, multiply and writeback in one cycle.
  - B = log2(N) * N / (2*PARALLEL) compute cycles; defaults give 1024.
  - start sampled at edge E0 -> busy=1 after E0; butterflies on edges E1..EB; done=1 and busy=0 after EB; done drops after E(B+1).
- Back-to-back: a new start is accepted the cycle after done. Memory keeps the previous result until overwritten by loads.

Optional Feature:
- Macro NTT_FWD_ASSERT_EN.
- When defined, simulation-only checks are compiled in:
  - Elaboration error if N is not a power of two, if ADDR_WIDTH ≠ log2(N), or if Q mod 2N ≠ 1.
  - Runtime error on load_data ≥ Q.
  - Warning on load_coeff or start while busy.
- When undefined, no checks exist. Functional behaviour is identical either way.

Test Plan:
- Reset: assert rst_n=0 mid-RUN -> done=0, busy=0, read_data=0 next cycle. All 256 reads then return 0.
- Impulse: load a[0]=1, rest 0, pulse start -> busy high 1024 cycles, then done high exactly 1 cycle. All 256 outputs = 1.
- Scaling: load a[0]=8380416 (Q-1), rest 0 -> all outputs 8380416. Then a[0]=5 with back-to-back start after done -> all outputs 5.
- Known answer: load a[i]=i for i=0..255 -> outputs match a software Dilithium reference NTT (zeta=1753) at every index. Read latency is exactly one cycle.
- Protocol: start and loads asserted during RUN -> ignored, done still exactly 1024 cycles after the first start, result unchanged.
- REDUCTION_TYPE=1 and PARALLEL=4 with the known-answer vector -> identical outputs, done after 256 cycles.
